// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch/scheduler bundle around the decode queue
// master (fetch + scheduler side) drives: hold, flush, ir_valid, iop_in, init_in,
//   pred_en, pred_sel, pred_pol, sf, id_req
// slave (decode_queue) drives: ir_ready, br_taken, pred_drop, id_feed, id_iop,
//   id_iop_init, count, empty, full
interface decode_queue_if #(
  parameter int IOP_W  = 32,
  parameter int INIT_W = 3,
  parameter int DEPTH  = 4,
  parameter int SF_W   = 8
);
  localparam int SEL_W = $clog2(SF_W);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic              hold;
  logic              flush;
  logic              ir_valid;
  logic              ir_ready;
  logic [IOP_W-1:0]  iop_in;
  logic [INIT_W-1:0] init_in;
  logic              pred_en;
  logic [SEL_W-1:0]  pred_sel;
  logic              pred_pol;
  logic [SF_W-1:0]   sf;
  logic              br_taken;
  logic              pred_drop;
  logic              id_req;
  logic              id_feed;
  logic [IOP_W-1:0]  id_iop;
  logic [INIT_W-1:0] id_iop_init;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  modport master (
    output hold, flush, ir_valid, iop_in, init_in, pred_en, pred_sel, pred_pol, sf, id_req,
    input  ir_ready, br_taken, pred_drop, id_feed, id_iop, id_iop_init, count, empty, full
  );
  modport slave (
    input  hold, flush, ir_valid, iop_in, init_in, pred_en, pred_sel, pred_pol, sf, id_req,
    output ir_ready, br_taken, pred_drop, id_feed, id_iop, id_iop_init, count, empty, full
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry iop FIFO with enqueue-time predicate resolution and redirect bubble
// clk, a_rst (async, active-low) are plain ports; everything else travels on q (slave modport)
module decode_queue #(
  parameter int IOP_W     = 32,
  parameter int INIT_W    = 3,
  parameter int DEPTH     = 4,
  parameter int SF_W      = 8,
  parameter int REDIR_CYC = 2
) (
  input logic           clk,
  input logic           a_rst,
  decode_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {RUN, REDIR} state_t;
  state_t            state_q, state_d;
  logic [3:0]        redir_q, redir_d;
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              br_q, br_d, drop_q, drop_d;
  logic [IOP_W-1:0]  iop_mem [DEPTH];
  logic [INIT_W-1:0] init_mem [DEPTH];
  logic [SF_W-1:0]   sf;
  logic              taken, acc, enq, deq, empty, full;
  assign sf    = q.sf;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(DEPTH);
  assign taken = ~q.pred_en | (sf[q.pred_sel] == q.pred_pol);
  assign deq   = q.id_req & ~empty & ~q.hold & ~q.flush;
  // a dequeue in the same cycle frees a slot, so a full queue can still accept
  assign q.ir_ready = (state_q == RUN) & ~q.hold & ~q.flush & (~full | deq);
  assign acc   = q.ir_valid & q.ir_ready;
  assign enq   = acc & taken;
  assign q.id_feed     = deq;
  assign q.id_iop      = empty ? '0 : iop_mem[rd_q];
  assign q.id_iop_init = empty ? '0 : init_mem[rd_q];
  assign q.count       = cnt_q;
  assign q.empty       = empty;
  assign q.full        = full;
  assign q.br_taken    = br_q;
  assign q.pred_drop   = drop_q;
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    redir_d = redir_q;
    // acc is already zero under hold/flush, so pulses are never re-issued there
    br_d    = acc & q.pred_en & taken;
    drop_d  = acc & q.pred_en & ~taken;
    if (q.flush) begin
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      state_d = RUN;
      redir_d = '0;
    end else if (!q.hold) begin
      wr_d  = enq ? wr_q + AW'(1) : wr_q;
      rd_d  = deq ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + CW'(enq) - CW'(deq);
      if (state_q == RUN && br_d) begin
        state_d = REDIR;
        redir_d = 4'(REDIR_CYC);
      end else if (state_q == REDIR) begin
        state_d = redir_q == 4'd1 ? RUN : REDIR;
        redir_d = redir_q - 4'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q <= RUN;
      redir_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      redir_q <= redir_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      drop_q  <= drop_d;
    end
  end
  // storage needs no reset: reads are gated to zero while empty
  always_ff @(posedge clk) begin
    if (enq) begin
      iop_mem[wr_q]  <= q.iop_in;
      init_mem[wr_q] <= q.init_in;
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: table-driven directed check of decode_queue
module tb_decode_queue;
  logic clk = 1'b0;
  logic a_rst = 1'b0;
  always #5 clk = ~clk;
  decode_queue_if #(.IOP_W(32), .INIT_W(3), .DEPTH(4), .SF_W(8)) bus ();
  decode_queue #(.IOP_W(32), .INIT_W(3), .DEPTH(4), .SF_W(8), .REDIR_CYC(2)) dut (
    .clk(clk), .a_rst(a_rst), .q(bus)
  );
  typedef struct {
    logic        h, f, iv;
    logic [31:0] iop;
    logic        pen;
    logic [2:0]  sel;
    logic        pol;
    logic [7:0]  sf;
    logic        req;
    logic        rdy, feed;
    logic [31:0] eiop;
    logic [2:0]  cnt;
    logic        br, dr;
  } vec_t;
  vec_t vq[$];
  int pass_n = 0;
  int total_n = 0;
  task automatic add(input logic h, f, iv, input logic [31:0] iop, input logic pen,
                     input logic [2:0] sel, input logic pol, input logic [7:0] sf, input logic req,
                     input logic rdy, feed, input logic [31:0] eiop, input logic [2:0] cnt,
                     input logic br, dr);
    vec_t v;
    v.h = h; v.f = f; v.iv = iv; v.iop = iop; v.pen = pen; v.sel = sel; v.pol = pol;
    v.sf = sf; v.req = req; v.rdy = rdy; v.feed = feed; v.eiop = eiop; v.cnt = cnt;
    v.br = br; v.dr = dr;
    vq.push_back(v);
  endtask
  task automatic drive(input logic h, f, iv, input logic [31:0] iop, input logic pen,
                       input logic [2:0] sel, input logic pol, input logic [7:0] sf, input logic req);
    bus.hold = h; bus.flush = f; bus.ir_valid = iv; bus.iop_in = iop; bus.init_in = iop[2:0];
    bus.pred_en = pen; bus.pred_sel = sel; bus.pred_pol = pol; bus.sf = sf; bus.id_req = req;
  endtask
  task automatic chk(input string nm, input logic rdy, feed, input logic [31:0] eiop,
                     input logic [2:0] cnt, input logic br, dr);
    logic [43:0] act, exp;
    act = {bus.ir_ready, bus.id_feed, bus.id_iop, bus.id_iop_init, bus.count, bus.empty,
           bus.full, bus.br_taken, bus.pred_drop};
    exp = {rdy, feed, eiop, eiop[2:0], cnt, cnt == 3'd0, cnt == 3'd4, br, dr};
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got rdy=%b feed=%b iop=%h init=%h cnt=%0d emp=%b full=%b br=%b drop=%b, want rdy=%b feed=%b iop=%h init=%h cnt=%0d emp=%b full=%b br=%b drop=%b",
                  nm, act[43], act[42], act[41:10], act[9:7], act[6:4], act[3], act[2], act[1], act[0],
                  exp[43], exp[42], exp[41:10], exp[9:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
  endtask
  initial begin
    add(0,0,1,32'hA1,0,0,0,8'h00,0, 1,0,32'h00,0,0,0);
    add(0,0,1,32'hB2,0,0,0,8'h00,0, 1,0,32'hA1,1,0,0);
    add(0,0,1,32'hC3,0,0,0,8'h00,0, 1,0,32'hA1,2,0,0);
    add(0,0,1,32'hD4,0,0,0,8'h00,0, 1,0,32'hA1,3,0,0);
    add(0,0,1,32'hE5,0,0,0,8'h00,0, 0,0,32'hA1,4,0,0);
    add(0,0,0,32'h00,0,0,0,8'h00,1, 1,1,32'hA1,4,0,0);
    add(0,0,0,32'h00,0,0,0,8'h00,1, 1,1,32'hB2,3,0,0);
    add(0,0,0,32'h00,0,0,0,8'h00,1, 1,1,32'hC3,2,0,0);
    add(0,0,0,32'h00,0,0,0,8'h00,1, 1,1,32'hD4,1,0,0);
    add(0,0,0,32'h00,0,0,0,8'h00,1, 1,0,32'h00,0,0,0);
    for (int k = 0; k < 4; k++)
      add(0,0,1,32'h10 + k,0,0,0,8'h00,0, 1,0,(k == 0 ? 32'h0 : 32'h10),3'(k),0,0);
    for (int k = 0; k < 6; k++)
      add(0,0,1,32'h14 + k,0,0,0,8'h00,1, 1,1,32'h10 + k,4,0,0);
    for (int k = 0; k < 4; k++)
      add(0,0,0,32'h00,0,0,0,8'h00,1, 1,1,32'h16 + k,3'(4 - k),0,0);
    add(0,0,1,32'h20,1,1,1,8'h00,0, 1,0,32'h00,0,0,0);
    add(0,0,0,32'h00,0,0,0,8'h00,0, 1,0,32'h00,0,0,1);
    add(0,0,0,32'h00,0,0,0,8'h00,0, 1,0,32'h00,0,0,0);
    add(0,0,1,32'h21,1,1,1,8'h02,0, 1,0,32'h00,0,0,0);
    add(0,0,1,32'h22,0,0,0,8'h00,0, 0,0,32'h21,1,1,0);
    add(0,0,1,32'h22,0,0,0,8'h00,0, 0,0,32'h21,1,0,0);
    add(0,0,1,32'h22,0,0,0,8'h00,0, 1,0,32'h21,1,0,0);
    add(0,0,0,32'h00,0,0,0,8'h00,0, 1,0,32'h21,2,0,0);
    add(0,0,1,32'h23,1,3,0,8'h00,0, 1,0,32'h21,2,0,0);
    add(1,0,1,32'h24,0,0,0,8'h00,0, 0,0,32'h21,3,1,0);
    add(1,0,1,32'h24,0,0,0,8'h00,0, 0,0,32'h21,3,0,0);
    add(1,0,1,32'h24,0,0,0,8'h00,0, 0,0,32'h21,3,0,0);
    add(0,0,1,32'h24,0,0,0,8'h00,0, 0,0,32'h21,3,0,0);
    add(0,0,1,32'h24,0,0,0,8'h00,0, 0,0,32'h21,3,0,0);
    add(0,0,0,32'h00,0,0,0,8'h00,0, 1,0,32'h21,3,0,0);
    add(0,1,1,32'h25,0,0,0,8'h00,1, 0,0,32'h21,3,0,0);
    add(0,0,0,32'h00,0,0,0,8'h00,1, 1,0,32'h00,0,0,0);
    drive(0,0,0,32'h0,0,0,0,8'h00,0);
    #12;
    chk("reset", 1,0,32'h0,0,0,0);
    @(negedge clk);
    a_rst = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].h, vq[i].f, vq[i].iv, vq[i].iop, vq[i].pen, vq[i].sel, vq[i].pol, vq[i].sf, vq[i].req);
      #1;
      chk($sformatf("vec%0d", i), vq[i].rdy, vq[i].feed, vq[i].eiop, vq[i].cnt, vq[i].br, vq[i].dr);
    end
    @(negedge clk);
    drive(0,0,1,32'h30,1,0,1,8'h01,0);
    #1;
    chk("taken_pre", 1,0,32'h0,0,0,0);
    @(negedge clk);
    drive(0,0,0,32'h0,0,0,0,8'h00,0);
    #1;
    chk("in_redir", 0,0,32'h30,1,1,0);
    #2;
    a_rst = 1'b0;
    #1;
    chk("async_rst", 1,0,32'h0,0,0,0);
    @(negedge clk);
    a_rst = 1'b1;
    #1;
    chk("post_rst", 1,0,32'h0,0,0,0);
    drive(0,0,1,32'h31,0,0,0,8'h00,0);
    @(negedge clk);
    drive(0,0,0,32'h0,0,0,0,8'h00,0);
    #1;
    chk("run_after_rst", 1,0,32'h31,1,0,0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor of the single-entry decode stage.
- Sits between instruction fetch and the scheduling queue.
- Accepts pre-decoded internal operations (iop + init bits) and buffers them in a DEPTH-entry FIFO.
- Resolves predicated ops against the status flags at enqueue, and sequences the fetch-redirect bubble through a small state machine.

Parameters:
- IOP_W, 32, width of an internal-operation word.
- INIT_W, 3, width of the iop init/step-mask field.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- SF_W, 8, status-flag vector width; power of two.
- REDIR_CYC, 2, bubble cycles after a taken predicated op (1..15).

Ports:
- clk  in  1  clock, rising edge
- a_rst  in  1  asynchronous reset, active-low
- hold  in  1  freezes all state; no enqueue, no dequeue
- flush  in  1  synchronous queue clear plus state return to RUN
- ir_valid  in  1  fetch presents a decoded op
- ir_ready  out  1  queue accepts the op this cycle
- iop_in  in  IOP_W  decoded iop
- init_in  in  INIT_W  iop init bits
- pred_en  in  1  op is predicated
- pred_sel  in  $clog2(SF_W)  flag index tested
- pred_pol  in  1  required flag value for taken
- sf  in  SF_W  current status flags
- br_taken  out  1  pulse: predicated op accepted and taken
- pred_drop  out  1  pulse: predicated op accepted but not taken (discarded)
- id_req  in  1  scheduler requests an op
- id_feed  out  1  head op delivered this cycle
- id_iop  out  IOP_W  head iop
- id_iop_init  out  INIT_W  head init bits
- count  out  $clog2(DEPTH+1)  occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH

Behaviour:
- Reset (a_rst low, async):
  - pointers and count 0; state RUN; redirect counter 0.
  - br_taken = 0, pred_drop = 0.
  - empty = 1, full = 0.
  - id_iop and id_iop_init read 0 while empty (output gated).
- Taken predicate: taken = ~pred_en | (sf[pred_sel] == pred_pol).
- Accept: acc = ir_valid & ir_ready.
  - ir_ready = (state == RUN) & ~hold & ~flush & (~full | deq).
- Enqueue: enq = acc & taken. The iop/init pair is written at the tail on the rising edge.
- Not-taken predicated ops:
  - consumed (acc = 1) but never stored;
  - pred_drop is a registered pulse, high the cycle after acc.
- Dequeue:
  - deq = id_req & ~empty & ~hold & ~flush.
  - id_feed = deq, combinational.
  - id_iop / id_iop_init are the head entry, combinational; head advances on the edge.
- Simultaneous enq and deq:
  - legal at any occupancy, including full; count unchanged.
  - When empty, enq and deq cannot coincide, so there is no bypass: minimum latency is enqueue at edge N, visible with id_feed at cycle N+1.
- Pointers wrap modulo DEPTH. count saturates logically: it never exceeds DEPTH or goes below 0. Overflow and underflow are impossible by construction.
- State machine:
  - RUN -> REDIR when acc & pred_en & taken.
    - br_taken pulses (registered) the cycle after acc.
    - Redirect counter loads REDIR_CYC.
  - REDIR: ir_ready = 0 and ir_valid is ignored. Counter decrements each non-hold cycle; at 1 -> RUN. Dequeue continues normally.
  - hold freezes state, counter and FIFO; pulses are not re-issued.
  - flush (any state): FIFO cleared (count 0, pointers 0), state RUN, counter 0, pulses suppressed that edge. flush wins over enq and deq in the same cycle.
- Reset asserted mid-operation clears everything asynchronously; entries are lost.

Test Plan:
- Fill/drain, DEPTH = 4: enqueue A..D with id_req = 0 -> full = 1, ir_ready = 0, count = 4. Then id_req = 1 for 4 cycles -> id_feed with A, B, C, D in order, empty = 1.
- Full with simultaneous enq and deq: at count = 4, ir_valid = 1 and id_req = 1 for 6 cycles -> ir_ready = 1 each cycle, count stays 4, output order preserved, pointers wrap cleanly.
- Predicate not taken: pred_en = 1, pred_sel = 1, pred_pol = 1, sf = 8'h00 -> acc = 1, pred_drop pulse the next cycle, count unchanged, br_taken = 0.
- Predicate taken, REDIR_CYC = 2: sf = 8'h02, same op -> entry stored, br_taken pulse, ir_ready low for exactly 2 cycles, then high.
- hold during REDIR: hold high for 3 cycles -> counter frozen; ir_ready returns high 2 non-hold cycles after the taken op.
- flush at count = 3, with id_req = 1 and ir_valid = 1 in the same cycle -> next cycle count = 0, empty = 1, no id_feed, state RUN. Async reset pulse mid-REDIR -> all outputs return to reset values immediately.
